// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch and debug request/response bundle for the instruction ROM arbiter
interface imem_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_flush;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    modport master (
        output fetch_req, fetch_addr, fetch_flush, dbg_req, dbg_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err
    );
    modport slave (
        input  fetch_req, fetch_addr, fetch_flush, dbg_req, dbg_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin share of the instruction ROM port between fetch and debug
module imem_arbiter #(
    parameter int SIZE    = 64,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_arbiter_if.slave      bus,
    output logic [31:0]        rom_a,
    input  logic [31:0]        rom_rd,
    output logic [STALL_W-1:0] fetch_stall_cnt
);
    logic        last_dbg;
    logic        f_el, d_el, gnt_f, gnt_d, any_gnt, in_range, stall;
    logic [31:0] sel_addr, cap_data;
    logic        f_rv, d_rv;

    // Arbitration and ROM addressing; grants are gated while in reset
    always_comb begin
        f_el     = rst_n & bus.fetch_req & ~bus.fetch_flush;
        d_el     = rst_n & bus.dbg_req;
        gnt_f    = f_el & (~d_el | last_dbg);
        gnt_d    = d_el & ~gnt_f;
        any_gnt  = gnt_f | gnt_d;
        sel_addr = gnt_f ? bus.fetch_addr : bus.dbg_addr;
        in_range = sel_addr < 32'(SIZE);
        rom_a    = (any_gnt && in_range) ? sel_addr : 32'd0;
        cap_data = in_range ? rom_rd : 32'd0;
        stall    = bus.fetch_req & ~bus.fetch_flush & ~gnt_f;
    end

    assign bus.fetch_gnt    = gnt_f;
    assign bus.dbg_gnt      = gnt_d;
    // A redirect also hides the fetch response landing in the same cycle
    assign bus.fetch_rvalid = f_rv & ~bus.fetch_flush;
    assign bus.dbg_rvalid   = d_rv;

    // Response capture, round-robin history and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg        <= 1'b1;
            f_rv            <= 1'b0;
            d_rv            <= 1'b0;
            bus.fetch_rdata <= '0;
            bus.fetch_err   <= 1'b0;
            bus.dbg_rdata   <= '0;
            bus.dbg_err     <= 1'b0;
            fetch_stall_cnt <= '0;
        end else begin
            if (any_gnt) last_dbg <= gnt_d;
            f_rv <= gnt_f;
            d_rv <= gnt_d;
            if (gnt_f) begin
                bus.fetch_rdata <= cap_data;
                bus.fetch_err   <= ~in_range;
            end
            if (gnt_d) begin
                bus.dbg_rdata <= cap_data;
                bus.dbg_err   <= ~in_range;
            end
            if (stall && !(&fetch_stall_cnt)) fetch_stall_cnt <= fetch_stall_cnt + 1'b1;
        end
    end
endmodule
